// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus per-bit stability filter for board switches and buttons.
// Emits clean levels and one-cycle rise/fall strobes on each accepted change.
//
// Per-bit behaviour (no explicit state register; implied by cnt and match):
//   state    | meaning
//   STABLE   | s2 == swt_clean, cnt held at 0
//   COUNTING | s2 != swt_clean, cnt advancing toward CNT_MAX-1
//   COMMIT   | mismatch with cnt == CNT_MAX-1: take new level, strobe once
module switch_debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] swt,
  output logic [WIDTH-1:0] swt_clean,
  output logic [WIDTH-1:0] swt_rise,
  output logic [WIDTH-1:0] swt_fall
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= swt;
      s2 <= s1;
    end
  end

  // Any return to the accepted level discards the partial count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst_n) begin
        cnt[i]       <= '0;
        swt_clean[i] <= 1'b0;
        swt_rise[i]  <= 1'b0;
        swt_fall[i]  <= 1'b0;
      end else if (s2[i] == swt_clean[i]) begin
        cnt[i]      <= '0;
        swt_rise[i] <= 1'b0;
        swt_fall[i] <= 1'b0;
      end else if (cnt[i] == CNT_TERM) begin
        cnt[i]       <= '0;
        swt_clean[i] <= s2[i];
        swt_rise[i]  <= s2[i];
        swt_fall[i]  <= ~s2[i];
      end else begin
        cnt[i]      <= cnt[i] + CNT_W'(1);
        swt_rise[i] <= 1'b0;
        swt_fall[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed vector table plus randomised bounce run for switch_debounce (CNT_MAX=4, WIDTH=2).
module tb_switch_debounce;

  localparam int WIDTH   = 2;
  localparam int CNT_MAX = 4;

  typedef struct {
    logic             rst_n;
    logic [WIDTH-1:0] swt;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] swt;
  logic [WIDTH-1:0] swt_clean;
  logic [WIDTH-1:0] swt_rise;
  logic [WIDTH-1:0] swt_fall;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  switch_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .swt       (swt),
    .swt_clean (swt_clean),
    .swt_rise  (swt_rise),
    .swt_fall  (swt_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add_n(input int n, input logic r, input logic [WIDTH-1:0] s,
                                input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] ri,
                                input logic [WIDTH-1:0] fa);
    vec_t v;
    v.rst_n = r; v.swt = s; v.clean = c; v.rise = ri; v.fall = fa;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  initial begin
    logic [WIDTH-1:0] prev_clean;
    logic [WIDTH-1:0] exp_rise;
    logic [WIDTH-1:0] exp_fall;
    int last_chg [WIDTH];
    int commits;

    rst_n = 1'b0;
    swt   = '0;

    // 1: reset with swt high, then requalify after release
    add_n(3, 0, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(5, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(1, 1, 2'b11, 2'b11, 2'b11, 2'b00);
    add_n(2, 1, 2'b11, 2'b11, 2'b00, 2'b00);
    // return both to low
    add_n(5, 1, 2'b00, 2'b11, 2'b00, 2'b00);
    add_n(1, 1, 2'b00, 2'b00, 2'b00, 2'b11);
    add_n(2, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 2: clean step on bit 0, up then down
    add_n(5, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(1, 1, 2'b01, 2'b01, 2'b01, 2'b00);
    add_n(2, 1, 2'b01, 2'b01, 2'b00, 2'b00);
    add_n(5, 1, 2'b00, 2'b01, 2'b00, 2'b00);
    add_n(1, 1, 2'b00, 2'b00, 2'b00, 2'b01);
    add_n(2, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3: 3-cycle glitch on bit 1 reaches cnt=CNT_MAX-1 but never commits
    add_n(3, 1, 2'b10, 2'b00, 2'b00, 2'b00);
    add_n(4, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int b = 0; b < 5; b++) begin
      add_n(2, 1, (b % 2 == 0) ? 2'b10 : 2'b00, 2'b00, 2'b00, 2'b00);
    end
    add_n(5, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 4: bit 0 one cycle ahead of bit 1
    add_n(1, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(4, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add_n(1, 1, 2'b11, 2'b01, 2'b01, 2'b00);
    add_n(1, 1, 2'b11, 2'b11, 2'b10, 2'b00);
    add_n(2, 1, 2'b11, 2'b11, 2'b00, 2'b00);
    add_n(5, 1, 2'b00, 2'b11, 2'b00, 2'b00);
    add_n(1, 1, 2'b00, 2'b00, 2'b00, 2'b11);
    add_n(2, 1, 2'b00, 2'b00, 2'b00, 2'b00);
    // 5: reset two counts into a qualification, then full requalify
    add_n(4, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(1, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(5, 1, 2'b01, 2'b00, 2'b00, 2'b00);
    add_n(1, 1, 2'b01, 2'b01, 2'b01, 2'b00);
    add_n(2, 1, 2'b01, 2'b01, 2'b00, 2'b00);

    for (int k = 0; k < vecs.size(); k++) begin
      rst_n = vecs[k].rst_n;
      swt   = vecs[k].swt;
      tick();
      check($sformatf("v%0d clean", k), swt_clean, vecs[k].clean);
      check($sformatf("v%0d rise", k),  swt_rise,  vecs[k].rise);
      check($sformatf("v%0d fall", k),  swt_fall,  vecs[k].fall);
    end

    // 6: random bouncy input, property checks every cycle
    commits = 0;
    for (int i = 0; i < WIDTH; i++) last_chg[i] = -1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 6) == 0) swt[i] = ~swt[i];
      end
      prev_clean = swt_clean;
      tick();
      exp_rise = swt_clean & ~prev_clean;
      exp_fall = ~swt_clean & prev_clean;
      check($sformatf("rnd%0d excl", cyc), swt_rise & swt_fall, '0);
      check($sformatf("rnd%0d rise", cyc), swt_rise, exp_rise);
      check($sformatf("rnd%0d fall", cyc), swt_fall, exp_fall);
      for (int i = 0; i < WIDTH; i++) begin
        if (swt_clean[i] != prev_clean[i]) begin
          commits++;
          checks++;
          if (cyc - last_chg[i] < CNT_MAX) begin
            errors++;
            $display("FAIL rnd%0d spacing bit%0d: got %0d cycles expected >= %0d",
                     cyc, i, cyc - last_chg[i], CNT_MAX);
          end
          last_chg[i] = cyc;
        end
      end
    end
    checks++;
    if (commits < 10) begin
      errors++;
      $display("FAIL rnd commits: got %0d expected >= 10", commits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
